// File: rtl/nios_screen_reader_niosii_cpu_div_cell.sv
// Iterative radix-2 restoring divider: one quotient bit per enabled cycle, results held until next done.
// Build macro NIOS_DIV_EARLY_ZERO_EN lets a zero divisor skip the iterations (PREP -> DONE).
module nios_screen_reader_niosii_cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_start,
  input  logic              E_div_signed,
  input  logic              M_en,
  input  logic              M_flush,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_quot,
  output logic [DATA_W-1:0] M_div_rem,
  output logic              M_div_by_zero
);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [DATA_W-1:0] quot_q, quot_d, remo_q, remo_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W+1:0] trial;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic zero_q, zero_d, byz_q, byz_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      byz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      byz_q   <= byz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    byz_d   = byz_q;
    // Shifted partial remainder minus divisor; the top bit is the borrow.
    trial   = {rem_q, dvd_q[DATA_W-1]} - {2'b00, dvs_q};

    if (M_flush) begin
      state_d = IDLE;
    end else if (M_en) begin
      case (state_q)
        IDLE, DONE: begin
          if (E_div_start) begin
            state_d = PREP;
            a_d     = E_src1;
            b_d     = E_src2;
            sgn_d   = E_div_signed;
          end else begin
            state_d = IDLE;
          end
        end
        PREP: begin
          dvd_d   = (sgn_q && a_q[DATA_W-1]) ? -a_q : a_q;
          dvs_d   = (sgn_q && b_q[DATA_W-1]) ? -b_q : b_q;
          qneg_d  = sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
          rneg_d  = sgn_q & a_q[DATA_W-1];
          zero_d  = (b_q == '0);
          rem_d   = '0;
          cnt_d   = CW'(DATA_W - 1);
          state_d = ITER;
`ifdef NIOS_DIV_EARLY_ZERO_EN
          if (b_q == '0) begin
            quot_d  = '1;
            remo_d  = a_q;
            byz_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
        ITER: begin
          rem_d = trial[DATA_W+1] ? {rem_q[DATA_W-1:0], dvd_q[DATA_W-1]} : trial[DATA_W:0];
          dvd_d = {dvd_q[DATA_W-2:0], ~trial[DATA_W+1]};
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - CW'(1);
        end
        FIX: begin
          // Zero divisor: iterations already gave all-ones; the remainder is the raw dividend.
          if (zero_q) begin
            quot_d = '1;
            remo_d = a_q;
            byz_d  = 1'b1;
          end else begin
            quot_d = qneg_q ? -dvd_q : dvd_q;
            remo_d = rneg_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
            byz_d  = 1'b0;
          end
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign M_div_busy    = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
  assign M_div_done    = (state_q == DONE);
  assign M_div_quot    = quot_q;
  assign M_div_rem     = remo_q;
  assign M_div_by_zero = byz_q;
endmodule
